// File: rtl/demux_stream_nch.sv
// Registered 1-to-NCH stream demultiplexer with a single-entry output register and full throughput.
// Words go to the in_sel channel (ADDRESSED) or to a round-robin pointer (SCAN); 1-cycle latency.
module demux_stream_nch #(
  parameter int                 WIDTH    = 1,
  parameter int                 SEL_W    = 2,
  parameter logic [WIDTH-1:0]   IDLE_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  output logic [(2**SEL_W)-1:0]       out_valid,
  input  logic [(2**SEL_W)-1:0]       out_ready,
  output logic [(2**SEL_W)*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]            scan_ptr
);

  localparam int NCH = 2**SEL_W;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [SEL_W-1:0]   scan_q, scan_d;
  logic               drain;
  logic               accept;

  assign drain    = (state_q == FULL) && out_ready[ch_q];
  assign in_ready = (state_q == EMPTY) || drain;
  assign accept   = in_valid && in_ready;
  assign scan_ptr = scan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      scan_q  <= scan_d;
    end
  end

  // A same-cycle drain and accept simply overwrite the register and stay FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    scan_d  = scan_q;
    if (accept) begin
      state_d = FULL;
      data_d  = in_data;
      ch_d    = mode ? scan_q : in_sel;
      if (mode) begin
        scan_d = scan_q + SEL_W'(1'b1);
      end
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = {NCH{IDLE_VAL}};
    for (int k = 0; k < NCH; k++) begin
      if ((state_q == FULL) && (ch_q == SEL_W'(k))) begin
        out_valid[k]                  = 1'b1;
        out_data[k*WIDTH +: WIDTH]    = data_q;
      end
    end
  end

endmodule
